// File: rtl/ex_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : ex_scoreboard
// Description : Load-use / intra-pair hazard tracker for the dual-issue EX
//               stage. Holds the issue pair (or slot 1) until every source
//               operand is obtainable by the EX forwarding muxes.
// Revision    : 1.0  initial release
// ============================================================================
module ex_scoreboard #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int LD_LAT        = 2,
    parameter int TMR_W         = 2,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ex_stall,

    input  logic                     issue0_valid,
    input  logic [RF_ADDR_WIDTH-1:0] issue0_rs1addr,
    input  logic [RF_ADDR_WIDTH-1:0] issue0_rs2addr,
    input  logic                     issue0_rs1_used,
    input  logic                     issue0_rs2_used,
    input  logic [RF_ADDR_WIDTH-1:0] issue0_rdaddr,
    input  logic                     issue0_RdWrtEn,
    input  logic                     issue0_is_load,

    input  logic                     issue1_valid,
    input  logic [RF_ADDR_WIDTH-1:0] issue1_rs1addr,
    input  logic [RF_ADDR_WIDTH-1:0] issue1_rs2addr,
    input  logic                     issue1_rs1_used,
    input  logic                     issue1_rs2_used,
    input  logic [RF_ADDR_WIDTH-1:0] issue1_rdaddr,
    input  logic                     issue1_RdWrtEn,
    input  logic                     issue1_is_load,

    output logic                     stall_issue0,
    output logic                     stall_issue1,
    output logic                     fire0,
    output logic                     fire1,
    output logic [NUM_REGS-1:0]      pending_vec,
    output logic [CNT_W-1:0]         hazard_stall_cnt
);

    localparam logic [TMR_W-1:0]         c_ld_lat = TMR_W'(LD_LAT);
    localparam logic [TMR_W-1:0]         c_one    = TMR_W'(1);
    localparam logic [RF_ADDR_WIDTH-1:0] c_x0     = '0;

    logic [TMR_W-1:0] r_timer     [NUM_REGS];
    logic [TMR_W-1:0] w_timer_nxt [NUM_REGS];
    logic [CNT_W-1:0] r_cnt;

    logic w_hit0_rs1, w_hit0_rs2, w_hit1_rs1, w_hit1_rs2;
    logic w_hazard0, w_hazard1, w_intra;
    logic w_wr0, w_wr1, w_cnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pending_vec[gi] = 1'b0;
            end else begin : g_xn
                assign pending_vec[gi] = (r_timer[gi] != '0);
            end
        end
    endgenerate

    // Hazard detection looks only at the registered timers.
    assign w_hit0_rs1 = issue0_rs1_used & (issue0_rs1addr != c_x0) & pending_vec[issue0_rs1addr];
    assign w_hit0_rs2 = issue0_rs2_used & (issue0_rs2addr != c_x0) & pending_vec[issue0_rs2addr];
    assign w_hit1_rs1 = issue1_rs1_used & (issue1_rs1addr != c_x0) & pending_vec[issue1_rs1addr];
    assign w_hit1_rs2 = issue1_rs2_used & (issue1_rs2addr != c_x0) & pending_vec[issue1_rs2addr];

    // Only a slot-0 load feeding slot 1 is unresolvable; ALU results forward.
    assign w_intra = issue0_valid & issue0_is_load & issue0_RdWrtEn & (issue0_rdaddr != c_x0)
                   & ((issue1_rs1_used & (issue1_rs1addr == issue0_rdaddr))
                   |  (issue1_rs2_used & (issue1_rs2addr == issue0_rdaddr)));

    assign w_hazard0 = issue0_valid & (w_hit0_rs1 | w_hit0_rs2);
    assign w_hazard1 = issue1_valid & (w_hit1_rs1 | w_hit1_rs2 | w_intra);

    assign stall_issue0 = w_hazard0 | ex_stall;
    assign stall_issue1 = stall_issue0 | w_hazard1;
    assign fire0        = issue0_valid & ~stall_issue0 & ~flush;
    assign fire1        = issue1_valid & ~stall_issue1 & ~flush;

    assign w_wr0     = fire0 & issue0_RdWrtEn & (issue0_rdaddr != c_x0);
    assign w_wr1     = fire1 & issue1_RdWrtEn & (issue1_rdaddr != c_x0);
    assign w_cnt_inc = issue0_valid & ~ex_stall & ~flush & (w_hazard0 | w_hazard1);

    assign hazard_stall_cnt = r_cnt;

    // Age, then slot 0 write, then slot 1 write so the younger slot wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_timer_nxt[i] = (r_timer[i] != '0) ? (r_timer[i] - c_one) : '0;
        end
        if (w_wr0) begin
            w_timer_nxt[issue0_rdaddr] = issue0_is_load ? c_ld_lat : '0;
        end
        if (w_wr1) begin
            w_timer_nxt[issue1_rdaddr] = issue1_is_load ? c_ld_lat : '0;
        end
        w_timer_nxt[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_timer[i] <= '0;
            end
            r_cnt <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_timer[i] <= '0;
            end
        end else if (!ex_stall) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_timer[i] <= w_timer_nxt[i];
            end
            if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_scoreboard
// Description : Self-checking bench for ex_scoreboard: directed scenarios,
//               ready-time reference model and literal spot checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_scoreboard;

    localparam int LD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall;
    logic        v0, u01, u02, we0, ld0;
    logic [4:0]  rs01, rs02, rd0;
    logic        v1, u11, u12, we1, ld1;
    logic [4:0]  rs11, rs12, rd1;
    logic        stall0, stall1, f0, f1;
    logic [31:0] pvec, cnt;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 0;

    ex_scoreboard #(
        .RF_ADDR_WIDTH(5), .NUM_REGS(32), .LD_LAT(LD_LAT), .TMR_W(2), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
        .issue0_valid(v0), .issue0_rs1addr(rs01), .issue0_rs2addr(rs02),
        .issue0_rs1_used(u01), .issue0_rs2_used(u02), .issue0_rdaddr(rd0),
        .issue0_RdWrtEn(we0), .issue0_is_load(ld0),
        .issue1_valid(v1), .issue1_rs1addr(rs11), .issue1_rs2addr(rs12),
        .issue1_rs1_used(u11), .issue1_rs2_used(u12), .issue1_rdaddr(rd1),
        .issue1_RdWrtEn(we1), .issue1_is_load(ld1),
        .stall_issue0(stall0), .stall_issue1(stall1), .fire0(f0), .fire1(f1),
        .pending_vec(pvec), .hazard_stall_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: each register carries the active-cycle number from
    // which it is readable again; ex_stall cycles do not advance time.
    int     act_cyc = 0;
    int     ready_at [32];
    longint m_cnt = 0;

    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && (ready_at[r] > act_cyc);
    endfunction

    always @(negedge clk) begin
        bit h0, h1, intra, e_s0, e_s1, e_f0, e_f1;
        logic [31:0] e_pv;
        if (chk_en) begin
            for (int r = 0; r < 32; r++) e_pv[r] = busy(5'(r));
            h0    = v0 && ((u01 && busy(rs01)) || (u02 && busy(rs02)));
            intra = v0 && ld0 && we0 && (rd0 != 0) &&
                    ((u11 && rs11 == rd0) || (u12 && rs12 == rd0));
            h1    = v1 && ((u11 && busy(rs11)) || (u12 && busy(rs12)) || intra);
            e_s0  = h0 || ex_stall;
            e_s1  = e_s0 || h1;
            e_f0  = v0 && !e_s0 && !flush;
            e_f1  = v1 && !e_s1 && !flush;
            check("stall_issue0", 64'(stall0), 64'(e_s0));
            check("stall_issue1", 64'(stall1), 64'(e_s1));
            check("fire0", 64'(f0), 64'(e_f0));
            check("fire1", 64'(f1), 64'(e_f1));
            check("pending_vec", 64'(pvec), 64'(e_pv));
            check("hazard_stall_cnt", 64'(cnt), 64'(m_cnt));
            if (rst) begin
                foreach (ready_at[r]) ready_at[r] = 0;
                m_cnt = 0;
            end else if (flush) begin
                foreach (ready_at[r]) ready_at[r] = 0;
            end else if (!ex_stall) begin
                if (v0 && (h0 || h1) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (e_f0 && we0 && rd0 != 0) ready_at[rd0] = ld0 ? act_cyc + LD_LAT + 1 : 0;
                if (e_f1 && we1 && rd1 != 0) ready_at[rd1] = ld1 ? act_cyc + LD_LAT + 1 : 0;
                act_cyc++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic slot0(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                         input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub);
        v0 = v; rd0 = rd; we0 = we; ld0 = ld; rs01 = a; u01 = ua; rs02 = b; u02 = ub;
    endtask

    task automatic slot1(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                         input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub);
        v1 = v; rd1 = rd; we1 = we; ld1 = ld; rs11 = a; u11 = ua; rs12 = b; u12 = ub;
    endtask

    task automatic idle();
        slot0(0, 0, 0, 0, 0, 0, 0, 0);
        slot1(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (ready_at[r]) ready_at[r] = 0;
        rst = 1; flush = 0; ex_stall = 0;
        slot0(1, 1, 1, 0, 2, 1, 3, 1);
        slot1(1, 4, 1, 0, 2, 1, 3, 1);
        #7 chk_en = 1;
        next_cycle();
        next_cycle(); rst = 0;
        #1;
        check("reset pending_vec", 64'(pvec), 64'd0);
        check("reset counter", 64'(cnt), 64'd0);
        check("post-reset fire0", 64'(f0), 64'd1);
        check("post-reset fire1", 64'(f1), 64'd1);

        // Load-use on x5
        next_cycle(); slot0(1, 5, 1, 1, 2, 1, 0, 0); slot1(0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("lu lw fire0", 64'(f0), 64'd1);
        next_cycle(); slot0(1, 6, 1, 0, 5, 1, 1, 1); #1;
        check("lu stall c1", 64'(stall0), 64'd1);
        next_cycle(); #1;
        check("lu stall c2", 64'(stall0), 64'd1);
        next_cycle(); #1;
        check("lu fire c3", 64'(f0), 64'd1);
        check("lu counter", 64'(cnt), 64'd2);

        // Intra-pair load dependency, then ALU version once x7 drains
        next_cycle(); slot0(1, 7, 1, 1, 2, 1, 0, 0); slot1(1, 8, 1, 0, 7, 1, 0, 1); #1;
        check("intra fire0", 64'(f0), 64'd1);
        check("intra stall1", 64'(stall1), 64'd1);
        check("intra fire1", 64'(f1), 64'd0);
        next_cycle(); idle(); #1;
        check("intra x7 pending", 64'(pvec[7]), 64'd1);
        next_cycle();
        next_cycle(); slot0(1, 7, 1, 0, 2, 1, 0, 0); slot1(1, 8, 1, 0, 7, 1, 0, 1); #1;
        check("alu pair fire1", 64'(f1), 64'd1);

        // WAW: slot-1 ALU write cancels slot-0 load to x9
        next_cycle(); slot0(1, 9, 1, 1, 2, 1, 0, 0); slot1(1, 9, 1, 0, 3, 1, 0, 0);
        next_cycle(); slot0(1, 13, 1, 0, 9, 1, 9, 1); slot1(0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("waw pending x9", 64'(pvec[9]), 64'd0);
        check("waw consumer fire0", 64'(f0), 64'd1);

        // ex_stall freezes the x10 timer and the counter
        next_cycle(); slot0(1, 10, 1, 1, 2, 1, 0, 0);
        next_cycle(); slot0(1, 14, 1, 0, 10, 1, 0, 0); ex_stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("freeze x10 pending", 64'(pvec[10]), 64'd1);
            check("freeze counter", 64'(cnt), 64'd3);
            next_cycle();
        end
        ex_stall = 0;
        next_cycle();
        next_cycle(); #1;
        check("thaw x10 cleared", 64'(pvec[10]), 64'd0);
        check("thaw fire0", 64'(f0), 64'd1);
        check("thaw counter", 64'(cnt), 64'd5);

        // x0 never tracked
        next_cycle(); slot0(1, 0, 1, 1, 2, 1, 0, 0);
        next_cycle(); slot0(1, 15, 1, 0, 0, 1, 0, 1); #1;
        check("x0 pending", 64'(pvec), 64'd0);
        check("x0 consumer fire0", 64'(f0), 64'd1);

        // Flush on top of a hazard
        next_cycle(); slot0(1, 11, 1, 1, 2, 1, 0, 0);
        next_cycle(); slot0(1, 16, 1, 0, 11, 1, 0, 0); flush = 1; #1;
        check("flush fire0", 64'(f0), 64'd0);
        next_cycle(); flush = 0; #1;
        check("flush pending", 64'(pvec), 64'd0);
        check("flush counter", 64'(cnt), 64'd5);
        check("post-flush fire0", 64'(f0), 64'd1);

        // Slot-1 load feeds next slot 0
        next_cycle(); slot0(1, 17, 1, 0, 2, 1, 0, 0); slot1(1, 18, 1, 1, 3, 1, 0, 0);
        next_cycle(); slot0(1, 19, 1, 0, 18, 0, 18, 1); slot1(1, 20, 1, 0, 2, 1, 0, 0); #1;
        check("slot1 load stall0", 64'(stall0), 64'd1);
        next_cycle(); next_cycle();

        // Reset mid-operation
        slot0(1, 12, 1, 1, 2, 1, 0, 0); slot1(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle(); rst = 1; idle();
        next_cycle(); rst = 0; #1;
        check("mid-reset pending", 64'(pvec), 64'd0);
        check("mid-reset counter", 64'(cnt), 64'd0);

        next_cycle(); next_cycle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
